// File: rtl/sam_mem_responder.sv
// Memory responder for the SAM CPU's multiplexed 8-bit bus: address latch on ALE,
// 256x8 memory, one output register, one synchronized input port, and a side load port.
module sam_mem_responder #(
  parameter logic [7:0] IO_OUT_ADDR = 8'hFF,
  parameter logic [7:0] IO_IN_ADDR  = 8'hFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic        ALE,
  input  logic        En,
  input  logic        Rw,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [7:0]  in_port,
  output logic [7:0]  out_port,
  output logic        err,
  output logic [15:0] acc_cnt,
  output logic        dbg_state,
  output logic [7:0]  dbg_addr
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t     state;
  logic [7:0] addr_q;
  logic [7:0] sync_q1;
  logic [7:0] in_sync;
  logic [7:0] mem [0:255];

  // Bus handshake: ALE alone marks an address phase; with ALE low, En qualifies a
  // data phase whose direction is Rw. A data phase is served only once an address
  // has been latched; the responder never stalls the CPU.
  logic addr_ph, rd_ph, wr_ph;
  logic rd_hit, wr_hit, bus_wr_ok, collide;

  always_comb begin
    addr_ph   = ALE;
    rd_ph     = !ALE && En && Rw;
    wr_ph     = !ALE && En && !Rw;
    rd_hit    = rd_ph && (state == ARMED);
    wr_hit    = wr_ph && (state == ARMED);
    collide   = wr_hit && ld_en;
    bus_wr_ok = wr_hit && !ld_en;
  end

  always_comb begin
    bus_oe  = 1'b0;
    bus_out = 8'h00;
    if (rd_hit) begin
      bus_oe = 1'b1;
      if (addr_q == IO_IN_ADDR)
        bus_out = in_sync;
      else if (addr_q == IO_OUT_ADDR)
        bus_out = out_port;
      else
        bus_out = mem[addr_q];
    end
  end

  // Single write port shared by the loader and the bus; memory survives reset.
  always_ff @(posedge clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (bus_wr_ok && (addr_q != IO_IN_ADDR) && (addr_q != IO_OUT_ADDR))
      mem[addr_q] <= bus_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 8'h00;
      out_port <= 8'h00;
      err      <= 1'b0;
      acc_cnt  <= 16'h0000;
      sync_q1  <= 8'h00;
      in_sync  <= 8'h00;
    end else begin
      sync_q1 <= in_port;
      in_sync <= sync_q1;
      if (addr_ph) begin
        state  <= ARMED;
        addr_q <= bus_in;
      end
      if ((rd_ph || wr_ph) && (state == IDLE))
        err <= 1'b1;
      if (collide)
        err <= 1'b1;
      if (rd_hit || wr_hit)
        acc_cnt <= acc_cnt + 16'h0001;
      if (bus_wr_ok && (addr_q == IO_OUT_ADDR))
        out_port <= bus_in;
    end
  end

  assign dbg_state = (state == ARMED);
  assign dbg_addr  = addr_q;

endmodule

// File: tb/tb_sam_mem_responder.sv
// Bench for sam_mem_responder: directed bus cycles, a bus-level reference model
// checked every cycle, and literal expectations from the test plan.
module tb_sam_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus_in = 8'h00;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        ALE = 1'b0, En = 1'b0, Rw = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h00, ld_data = 8'h00;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port;
  logic        err;
  logic [15:0] acc_cnt;
  logic        dbg_state;
  logic [7:0]  dbg_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sam_mem_responder dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .ALE(ALE), .En(En), .Rw(Rw), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_port(in_port), .out_port(out_port), .err(err), .acc_cnt(acc_cnt),
    .dbg_state(dbg_state), .dbg_addr(dbg_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bus-level view of the responder.
  logic [7:0]  m_mem [0:255];
  bit          m_armed = 1'b0;
  logic [7:0]  m_addr = 8'h00, m_out = 8'h00;
  bit          m_err = 1'b0;
  logic [15:0] m_cnt = 16'h0000;
  logic [7:0]  m_hist [$] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    bit rd, wr;
    rd = !ALE && En && Rw;
    wr = !ALE && En && !Rw;
    if (ld_en) m_mem[ld_addr] = ld_data;
    if (rst) begin
      m_armed = 0; m_addr = 8'h00; m_out = 8'h00; m_err = 0; m_cnt = 16'h0000;
      m_hist = '{8'h00, 8'h00};
    end else begin
      m_hist.push_back(in_port);
      void'(m_hist.pop_front());
      if (ALE) begin
        m_armed = 1; m_addr = bus_in;
      end else if (rd || wr) begin
        if (!m_armed) m_err = 1;
        else begin
          m_cnt = m_cnt + 16'd1;
          if (wr) begin
            if (ld_en) m_err = 1;
            else if (m_addr == 8'hFF) m_out = bus_in;
            else if (m_addr != 8'hFE) m_mem[m_addr] = bus_in;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic       e_oe;
    logic [7:0] e_out;
    if (chk_en) begin
      e_oe  = !ALE && En && Rw && m_armed;
      e_out = 8'h00;
      if (e_oe) e_out = (m_addr == 8'hFE) ? m_hist[0] : (m_addr == 8'hFF) ? m_out : m_mem[m_addr];
      chk("m_bus_oe", {15'd0, bus_oe}, {15'd0, e_oe});
      chk("m_bus_out", {8'd0, bus_out}, {8'd0, e_out});
      chk("m_out_port", {8'd0, out_port}, {8'd0, m_out});
      chk("m_err", {15'd0, err}, {15'd0, m_err});
      chk("m_acc_cnt", acc_cnt, m_cnt);
      chk("m_state", {15'd0, dbg_state}, {15'd0, m_armed});
      chk("m_addr", {8'd0, dbg_addr}, {8'd0, m_addr});
    end
  end

  // Advance one cycle, apply inputs, then wait to mid-cycle for sampling.
  task automatic drv(input logic a, input logic e, input logic r, input logic [7:0] b,
                     input logic l = 1'b0, input logic [7:0] la = 8'h00,
                     input logic [7:0] lb = 8'h00, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    ALE = a; En = e; Rw = r; bus_in = b;
    ld_en = l; ld_addr = la; ld_data = lb; rst = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle();
  endtask

  initial begin
    // Preload all memory during reset so every read has a defined value.
    for (int i = 0; i < 256; i++)
      drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 8'(i) ^ 8'h3C, 1'b1);
    chk_en = 1'b1;
    idle();
    chk("rst_bus_oe", {15'd0, bus_oe}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_acc_cnt", acc_cnt, 16'h0000);
    chk("rst_out_port", {8'd0, out_port}, 16'h0000);
    chk("rst_state", {15'd0, dbg_state}, 16'd0);
    chk("load_during_rst", {8'd0, dut.mem[8'h05]}, 16'h0039);

    // Load and read
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h6A);
    drv(1'b1, 1'b0, 1'b0, 8'h10);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("ld_rd_oe", {15'd0, bus_oe}, 16'd1);
    chk("ld_rd_data", {8'd0, bus_out}, 16'h006A);
    idle();
    chk("ld_rd_cnt", acc_cnt, 16'd1);

    // Write then read at a held address
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 8'h20);
    drv(1'b0, 1'b1, 1'b0, 8'hC3);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("wr_rd1", {8'd0, bus_out}, 16'h00C3);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("wr_rd2", {8'd0, bus_out}, 16'h00C3);
    idle();
    chk("wr_rd_cnt", acc_cnt, 16'd3);

    // ALE with En high is an address phase only
    drv(1'b1, 1'b1, 1'b0, 8'h21);
    chk("ale_en_oe", {15'd0, bus_oe}, 16'd0);
    idle();
    chk("ale_en_mem", {8'd0, dut.mem[8'h21]}, 16'h001D);
    chk("ale_en_cnt", acc_cnt, 16'd3);

    // I/O map
    drv(1'b1, 1'b0, 1'b0, 8'hFF);
    drv(1'b0, 1'b1, 1'b0, 8'h5A);
    in_port = 8'h81;
    idle();
    chk("io_out_port", {8'd0, out_port}, 16'h005A);
    drv(1'b1, 1'b0, 1'b0, 8'hFE);
    drv(1'b0, 1'b1, 1'b0, 8'h77);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("io_in_read", {8'd0, bus_out}, 16'h0081);
    drv(1'b1, 1'b0, 1'b0, 8'hFF);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("io_out_read", {8'd0, bus_out}, 16'h005A);
    idle();
    chk("io_mem_ff", {8'd0, dut.mem[8'hFF]}, 16'h00C3);
    chk("io_mem_fe", {8'd0, dut.mem[8'hFE]}, 16'h00C2);

    // Protocol error
    do_reset();
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("perr_oe", {15'd0, bus_oe}, 16'd0);
    idle();
    chk("perr_err", {15'd0, err}, 16'd1);
    chk("perr_cnt", acc_cnt, 16'd0);
    drv(1'b1, 1'b0, 1'b0, 8'h10);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("perr_valid_rd", {8'd0, bus_out}, 16'h006A);
    idle();
    chk("perr_sticky", {15'd0, err}, 16'd1);

    // Load/bus write collision
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 8'h30);
    drv(1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h30, 8'h99);
    idle();
    chk("coll_err", {15'd0, err}, 16'd1);
    chk("coll_cnt", acc_cnt, 16'd1);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("coll_read", {8'd0, bus_out}, 16'h0099);

    // Counter wrap, then reset between ALE and its read phase
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 8'hFF);
    drv(1'b0, 1'b1, 1'b0, 8'h77);
    drv(1'b1, 1'b0, 1'b0, 8'h40);
    for (int i = 0; i < 65534; i++)
      drv(1'b0, 1'b1, 1'b1, 8'h00);
    idle();
    chk("wrap_pre", acc_cnt, 16'hFFFF);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    idle();
    chk("wrap_post", acc_cnt, 16'h0000);
    drv(1'b1, 1'b0, 1'b0, 8'h50);
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 8'h00);
    chk("mid_rst_state", {15'd0, dbg_state}, 16'd0);
    chk("mid_rst_addr", {8'd0, dbg_addr}, 16'h0000);
    chk("mid_rst_out", {8'd0, out_port}, 16'h0000);
    chk("mid_rst_oe", {15'd0, bus_oe}, 16'd0);
    chk("mid_rst_mem10", {8'd0, dut.mem[8'h10]}, 16'h006A);
    chk("mid_rst_mem20", {8'd0, dut.mem[8'h20]}, 16'h00C3);
    idle();
    chk("mid_rst_err", {15'd0, err}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sam_mem_responder.md
# sam_mem_responder

Bus-side memory responder for the SAM CPU's multiplexed 8-bit address/data bus. It latches addresses on ALE, serves reads and accepts writes on En/Rw data phases, and holds 256×8 program/data memory. It also maps one output register and one synchronized input port into the address space, and provides a side load port so a bench or boot block can preload programs. It sits opposite the CPU controller on the shared bus; the top level resolves the tristate from `bus_out` and `bus_oe`.

## Interface
- `IO_OUT_ADDR`, default 8'hFF: address of the memory-mapped output register.
- `IO_IN_ADDR`, default 8'hFE: address of the read-only input port.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `bus_in` in 8: bus value as seen by the responder.
- `bus_out` out 8: read data driven toward the bus.
- `bus_oe` out 1: responder drives the bus this cycle.
- `ALE` in 1: address latch enable.
- `En` in 1: bus cycle enable.
- `Rw` in 1: 1 = read, 0 = write.
- `ld_en` in 1: side-port write strobe.
- `ld_addr` in 8: side-port write address.
- `ld_data` in 8: side-port write data.
- `in_port` in 8: asynchronous external input.
- `out_port` out 8: registered output register.
- `err` out 1: sticky protocol-error flag.
- `acc_cnt` out 16: count of completed data phases.

## Operation
- **Phase decode, evaluated each cycle:**
  - Address phase: `ALE=1`, regardless of `En`/`Rw`.
  - Read phase: `ALE=0`, `En=1`, `Rw=1`.
  - Write phase: `ALE=0`, `En=1`, `Rw=0`.
  - Idle: anything else.
- **FSM states:**
  - IDLE: no valid address.
  - ARMED: `addr_q` valid.
- **Transitions:**
  - Any state, address phase → ARMED; `addr_q <= bus_in`.
  - ARMED stays ARMED across any number of data phases; the address is held until the next ALE. There is no auto-increment.
  - IDLE with a read or write phase → sets `err`, remains IDLE. No memory access occurs, `bus_oe` stays 0, and `acc_cnt` does not increment.
- **Read phase in ARMED:**
  - `bus_oe=1` combinationally in the same cycle.
  - `bus_out` source by `addr_q`:
    - `IO_IN_ADDR`: `in_sync`.
    - `IO_OUT_ADDR`: `out_port`.
    - Otherwise: `mem[addr_q]`.
- **Write phase in ARMED:**
  - At the clock edge, `bus_in` is written to `out_port` if `addr_q==IO_OUT_ADDR`.
  - Writes to `IO_IN_ADDR` are discarded without error.
  - Otherwise `mem[addr_q] <= bus_in`.
  - `mem` at `IO_IN_ADDR`/`IO_OUT_ADDR` is never written from the bus.
- **Side load port:** `ld_en=1` writes `mem[ld_addr] <= ld_data`, at any address including the I/O addresses, and in any state including during `rst`.
- **Single write port:** if `ld_en=1` coincides with a bus write phase in ARMED, the load wins. The bus write is dropped entirely (memory and `out_port` unchanged) and `err` is set.
- **`acc_cnt`:** increments by 1 per read or write phase completed in ARMED, including dropped writes. It wraps from FFFF to 0000.
- **Input synchronizer:** `in_port` passes through a 2-flop synchronizer to give `in_sync`.
- **Outputs when not driving:** `bus_oe=0` and `bus_out=8'h00` whenever not in a read phase in ARMED.

## Timing
- **Reset values** (cycle after a `rst`-high edge):
  - State IDLE, `addr_q=0`, `bus_oe=0`, `bus_out=0`.
  - `out_port=0`, `err=0`, `acc_cnt=0`, synchronizer flops 0.
- **Memory across reset:** memory contents are not cleared by `rst`. A load-port write during `rst` still takes effect.
- **Reset mid-operation:** returns to IDLE. The next data phase without a fresh ALE flags `err`.
- **Address latch:** 1 edge. A data phase may follow in the very next cycle.
- **Read latency:** 0 cycles. Data is valid combinationally during the read-phase cycle, for the CPU to capture on that cycle's closing edge.
- **Write latency:** 1 edge. Data is readable in the following cycle's read phase.
- **`in_port` → readable:** 2 edges.
- **`err`:** sticky, set on the edge that closes the offending cycle, cleared only by `rst`.
- **ALE together with En=1:** the cycle is an address phase only. No data is driven or written.

## Test plan
- **Load and read:**
  - Stimulus: load `mem[8'h10]=8'h6A` via `ld_*`, then ALE with `bus_in=8'h10`, then a read phase.
  - Required: `bus_oe=1`, `bus_out=8'h6A` in that cycle; `acc_cnt=1`.
- **Write then read, held address:**
  - Stimulus: ALE with `bus_in=8'h20`, write phase `bus_in=8'hC3`, then two read phases with no new ALE.
  - Required: both reads return `8'hC3`; `acc_cnt=3`.
- **I/O map:**
  - Stimulus: write `8'h5A` to `8'hFF`; then `in_port=8'h81` held ≥2 cycles and read `8'hFE`; then read `8'hFF`.
  - Required: `out_port=8'h5A`; the reads return `8'h81` and `8'h5A`; `mem[8'hFF]` unchanged.
- **Protocol error:**
  - Stimulus: after `rst`, a read phase with no prior ALE.
  - Required: `bus_oe=0`, `err=1` next cycle, `acc_cnt=0`. `err` stays 1 through a subsequent valid access.
- **Load/bus write collision:**
  - Stimulus: ARMED at `8'h30`; same cycle, bus write `8'h11` and `ld_en` with `ld_addr=8'h30`, `ld_data=8'h99`.
  - Required: read of `8'h30` returns `8'h99`; `err=1`; `acc_cnt` incremented by 1.
- **Reset mid-operation and wrap:**
  - Stimulus: preset `acc_cnt` to FFFF via 65535 reads, then one more read; assert `rst` between an ALE and its read phase.
  - Required: `acc_cnt` wraps to 0000. After `rst`: `addr_q=0`, state IDLE, `out_port=0`, and memory contents intact.
